// File: rtl/usb_bus_state_ctrl.sv
// rtl/usb_bus_state_ctrl.sv - USB full-speed device bus-state controller (attach/reset/active/suspend/resume)
// Optional remote wakeup support: define USB_REMOTE_WAKEUP_EN.
module usb_bus_state_ctrl #(
   parameter int RESET_CYCLES     = 120,
   parameter int SUSPEND_CYCLES   = 144000,
   parameter int RESUME_CYCLES    = 960,
`ifdef USB_REMOTE_WAKEUP_EN
   parameter int WAKE_IDLE_CYCLES = 240000,
   parameter int WAKE_K_CYCLES    = 96000,
`endif
   parameter int CNT_W            = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       line_state_valid,
   input  logic [1:0] line_state,
`ifdef USB_REMOTE_WAKEUP_EN
   input  logic       remote_wakeup_req,
   output logic       drive_k,
`endif
   output logic [2:0] bus_state,
   output logic       bus_reset_pulse,
   output logic       in_reset,
   output logic       suspended,
   output logic       resume_pulse,
   output logic       active
);

   typedef enum logic [2:0] {
      ST_ATTACHED  = 3'd0,
      ST_BUS_RESET = 3'd1,
      ST_ACTIVE    = 3'd2,
      ST_SUSPENDED = 3'd3,
      ST_RESUMING  = 3'd4
   } state_t;

   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_J   = 2'b01;
   localparam logic [1:0] LS_K   = 2'b10;

   localparam logic [CNT_W-1:0] RUN_MAX   = '1;
   localparam logic [CNT_W-1:0] RUN_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] RESET_N   = CNT_W'(RESET_CYCLES);
   localparam logic [CNT_W-1:0] SUSPEND_N = CNT_W'(SUSPEND_CYCLES);
   localparam logic [CNT_W-1:0] RESUME_N  = CNT_W'(RESUME_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] run_len, run_next;
   logic [1:0]       last_ls;
   logic             eop_seen;
   logic             run_step;
   logic             se0_n, j_n, k_n;

`ifdef USB_REMOTE_WAKEUP_EN
   localparam logic [CNT_W-1:0] WAKE_IDLE_N = CNT_W'(WAKE_IDLE_CYCLES);
   localparam logic [CNT_W-1:0] WAKE_K_N    = CNT_W'(WAKE_K_CYCLES);

   logic [CNT_W-1:0] susp_cnt, susp_next;
   logic [CNT_W-1:0] wake_cnt, wake_cnt_d;
   logic             wake_d;
`endif

   // A run continues only while consecutive samples are valid and identical.
   always_comb begin
      run_next = '0;
      if (line_state_valid) begin
         if (run_len != '0 && line_state == last_ls)
            run_next = (run_len == RUN_MAX) ? RUN_MAX : run_len + RUN_ONE;
         else
            run_next = RUN_ONE;
      end
   end

   // run_step blocks re-firing when a saturated run sits exactly on a threshold.
   assign run_step = (run_next != run_len);
   assign se0_n    = line_state_valid && line_state == LS_SE0 && run_next == RESET_N   && run_step;
   assign j_n      = line_state_valid && line_state == LS_J   && run_next == SUSPEND_N && run_step;
   assign k_n      = line_state_valid && line_state == LS_K   && run_next == RESUME_N  && run_step;

   always_comb begin
      state_d = state_q;
`ifdef USB_REMOTE_WAKEUP_EN
      wake_d     = 1'b0;
      wake_cnt_d = '0;
`endif
      case (state_q)
         ST_ATTACHED: begin
            if (j_n)
               state_d = ST_SUSPENDED;
         end
         ST_BUS_RESET: begin
            if (line_state_valid && line_state != LS_SE0)
               state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (j_n)
               state_d = ST_SUSPENDED;
         end
         ST_SUSPENDED: begin
`ifdef USB_REMOTE_WAKEUP_EN
            // While we drive K ourselves the line K run must not look like a host resume.
            if (drive_k) begin
               if (wake_cnt == WAKE_K_N) begin
                  state_d = ST_RESUMING;
               end else begin
                  wake_d     = 1'b1;
                  wake_cnt_d = wake_cnt + RUN_ONE;
               end
            end else if (remote_wakeup_req && susp_cnt >= WAKE_IDLE_N) begin
               wake_d     = 1'b1;
               wake_cnt_d = RUN_ONE;
            end else if (k_n) begin
               state_d = ST_RESUMING;
            end
`else
            if (k_n)
               state_d = ST_RESUMING;
`endif
         end
         ST_RESUMING: begin
            if (line_state_valid && line_state == LS_J && eop_seen)
               state_d = ST_ACTIVE;
         end
         default: state_d = ST_ATTACHED;
      endcase
      if (se0_n) begin
         state_d = ST_BUS_RESET;
`ifdef USB_REMOTE_WAKEUP_EN
         wake_d     = 1'b0;
         wake_cnt_d = '0;
`endif
      end
   end

`ifdef USB_REMOTE_WAKEUP_EN
   // Counts cycles spent in SUSPENDED, 1 in the first such cycle.
   always_comb begin
      susp_next = '0;
      if (state_d == ST_SUSPENDED) begin
         if (state_q != ST_SUSPENDED)
            susp_next = RUN_ONE;
         else
            susp_next = (susp_cnt == RUN_MAX) ? RUN_MAX : susp_cnt + RUN_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         susp_cnt <= '0;
         wake_cnt <= '0;
         drive_k  <= 1'b0;
      end else begin
         susp_cnt <= susp_next;
         wake_cnt <= wake_cnt_d;
         drive_k  <= wake_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_ATTACHED;
         run_len         <= '0;
         last_ls         <= LS_SE0;
         eop_seen        <= 1'b0;
         bus_reset_pulse <= 1'b0;
         in_reset        <= 1'b0;
         suspended       <= 1'b0;
         resume_pulse    <= 1'b0;
         active          <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_len  <= run_next;
         eop_seen <= line_state_valid && line_state == LS_SE0;
         if (line_state_valid)
            last_ls <= line_state;
         bus_reset_pulse <= se0_n;
         in_reset        <= (state_d == ST_BUS_RESET);
         suspended       <= (state_d == ST_SUSPENDED);
         resume_pulse    <= (state_d == ST_RESUMING) && (state_q != ST_RESUMING);
         active          <= (state_d == ST_ACTIVE);
      end
   end

   assign bus_state = state_q;

endmodule

// File: tb/tb_usb_bus_state_ctrl.sv
// tb/tb_usb_bus_state_ctrl.sv - table, corner-case and random checks for usb_bus_state_ctrl
module tb_usb_bus_state_ctrl;

   localparam int RST_N  = 4;
   localparam int SUSP_N = 16;
   localparam int RES_N  = 8;
   localparam int S_ATT = 0, S_RST = 1, S_ACT = 2, S_SUS = 3, S_RES = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_state_valid = 1'b0;
   logic [1:0] line_state = 2'b01;
   logic [2:0] bus_state;
   logic       bus_reset_pulse, in_reset, suspended, resume_pulse, active;
`ifdef USB_REMOTE_WAKEUP_EN
   logic       remote_wakeup_req = 1'b0;
   logic       drive_k;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   usb_bus_state_ctrl #(
      .RESET_CYCLES(RST_N),
      .SUSPEND_CYCLES(SUSP_N),
      .RESUME_CYCLES(RES_N),
`ifdef USB_REMOTE_WAKEUP_EN
      .WAKE_IDLE_CYCLES(10),
      .WAKE_K_CYCLES(5),
`endif
      .CNT_W(18)
   ) dut (
      .clk(clk),
      .rst(rst),
      .line_state_valid(line_state_valid),
      .line_state(line_state),
`ifdef USB_REMOTE_WAKEUP_EN
      .remote_wakeup_req(remote_wakeup_req),
      .drive_k(drive_k),
`endif
      .bus_state(bus_state),
      .bus_reset_pulse(bus_reset_pulse),
      .in_reset(in_reset),
      .suspended(suspended),
      .resume_pulse(resume_pulse),
      .active(active)
   );

   // Reference model: sample history, run length recounted from the tail each cycle.
   int hist[$];
   int m_state;
   bit m_brp, m_rp;

   task automatic model_reset();
      hist.delete();
      m_state = S_ATT;
      m_brp   = 1'b0;
      m_rp    = 1'b0;
   endtask

   task automatic model_step(input bit v, input logic [1:0] ls);
      int code, prev, run, nxt;
      bit se0, j, k;
      code = v ? int'(ls) : -1;
      prev = (hist.size() > 0) ? hist[hist.size()-1] : -1;
      hist.push_back(code);
      if (hist.size() > 40) void'(hist.pop_front());
      run = 0;
      if (code >= 0)
         for (int i = hist.size() - 1; i >= 0 && hist[i] == code; i--) run++;
      se0 = (code == 0) && (run == RST_N);
      j   = (code == 1) && (run == SUSP_N);
      k   = (code == 2) && (run == RES_N);
      nxt = m_state;
      case (m_state)
         S_ATT, S_ACT: if (j) nxt = S_SUS;
         S_RST:        if (code == 1 || code == 2) nxt = S_ACT;
         S_SUS:        if (k) nxt = S_RES;
         S_RES:        if (code == 1 && prev == 0) nxt = S_ACT;
         default:      nxt = m_state;
      endcase
      if (se0) nxt = S_RST;
      m_brp   = se0;
      m_rp    = (nxt == S_RES) && (m_state != S_RES);
      m_state = nxt;
   endtask

   task automatic step(input bit v, input logic [1:0] ls);
      line_state_valid = v;
      line_state       = ls;
      model_step(v, ls);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int st, input bit brp, input bit rp);
      bit ok;
      vectors++;
      ok = (int'(bus_state) == st) && (bus_reset_pulse == brp) && (resume_pulse == rp) &&
           (in_reset == (st == S_RST)) && (suspended == (st == S_SUS)) && (active == (st == S_ACT));
`ifdef USB_REMOTE_WAKEUP_EN
      ok = ok && (drive_k == 1'b0);
`endif
      if (!ok) begin
         miscompares++;
         $display("FAIL %s @%0t: got state=%0d brp=%0b rp=%0b in_reset=%0b suspended=%0b active=%0b, expected state=%0d brp=%0b rp=%0b",
                  name, $time, bus_state, bus_reset_pulse, resume_pulse, in_reset, suspended, active, st, brp, rp);
      end
   endtask

   task automatic check_model(input string name);
      check(name, m_state, m_brp, m_rp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      line_state_valid = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", S_ATT, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

`ifdef USB_REMOTE_WAKEUP_EN
   task automatic wchk(input string name, input int st, input bit dk, input bit rp);
      vectors++;
      if (int'(bus_state) != st || drive_k != dk || resume_pulse != rp) begin
         miscompares++;
         $display("FAIL %s @%0t: got state=%0d drive_k=%0b rp=%0b, expected state=%0d drive_k=%0b rp=%0b",
                  name, $time, bus_state, drive_k, resume_pulse, st, dk, rp);
      end
   endtask
`endif

   typedef struct {
      bit         v;
      logic [1:0] ls;
      int         st;
      bit         brp;
      bit         rp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit v, input logic [1:0] ls, input int st, input bit brp, input bit rp, input int n);
      vec_t e;
      e.v = v; e.ls = ls; e.st = st; e.brp = brp; e.rp = rp;
      for (int i = 0; i < n; i++) tbl.push_back(e);
   endtask

   initial begin
      int sym, len;
      bit rv;
      logic [1:0] rls;

      // SE0 = 0, J = 1, K = 2, invalid = v 0
      add(1, 0, S_ATT, 0, 0, 3);  add(1, 0, S_RST, 1, 0, 1);
      add(1, 1, S_ACT, 0, 0, 1);  add(1, 2, S_ACT, 0, 0, 1);
      add(1, 1, S_ACT, 0, 0, 15); add(1, 2, S_ACT, 0, 0, 1);
      add(1, 1, S_ACT, 0, 0, 15); add(1, 1, S_SUS, 0, 0, 1);
      add(1, 2, S_SUS, 0, 0, 7);  add(0, 3, S_SUS, 0, 0, 1);
      add(1, 2, S_SUS, 0, 0, 7);  add(1, 2, S_RES, 0, 1, 1);
      add(1, 0, S_RES, 0, 0, 2);  add(1, 1, S_ACT, 0, 0, 1);
      add(1, 1, S_ACT, 0, 0, 14); add(1, 1, S_SUS, 0, 0, 1);
      add(1, 0, S_SUS, 0, 0, 3);  add(1, 0, S_RST, 1, 0, 1);
      add(1, 1, S_ACT, 0, 0, 1);  add(1, 0, S_ACT, 0, 0, 3);
      add(1, 1, S_ACT, 0, 0, 1);
      // bus reset re-entered after an illegal sample pulses again
      add(1, 0, S_ACT, 0, 0, 3);  add(1, 0, S_RST, 1, 0, 1);
      add(1, 0, S_RST, 0, 0, 2);  add(0, 3, S_RST, 0, 0, 1);
      add(1, 0, S_RST, 0, 0, 3);  add(1, 0, S_RST, 1, 0, 1);
      add(1, 1, S_ACT, 0, 0, 1);

      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].ls);
         check($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].brp, tbl[i].rp);
      end

      // Reach RESUMING, then assert rst between clock edges.
      for (int i = 0; i < 15; i++) step(1, 2'b01);
      check("pre_rst_susp", S_SUS, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1, 2'b10);
      check("pre_rst_resuming", S_RES, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1 check("async_rst", S_ATT, 1'b0, 1'b0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

`ifdef USB_REMOTE_WAKEUP_EN
      for (int i = 0; i < 15; i++) step(1, 2'b01);
      check("wake_attached", S_ATT, 1'b0, 1'b0);
      step(1, 2'b01);
      check("wake_enter_susp", S_SUS, 1'b0, 1'b0);
      for (int c = 1; c <= 11; c++) begin
         remote_wakeup_req = (c == 5);
         step(1, 2'b01);
         wchk("wake_too_early", S_SUS, 1'b0, 1'b0);
      end
      remote_wakeup_req = 1'b1;
      step(1, 2'b01);
      remote_wakeup_req = 1'b0;
      wchk("wake_drive_k", S_SUS, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1, 2'b01);
         wchk("wake_drive_k", S_SUS, 1'b1, 1'b0);
      end
      step(1, 2'b01);
      wchk("wake_resuming", S_RES, 1'b0, 1'b1);
`endif

      do_reset();
      for (int r = 0; r < 160; r++) begin
         sym = $urandom_range(0, 9);
         if (sym == 0) begin
            rv = 1'b0; rls = 2'b11; len = $urandom_range(1, 2);
         end else begin
            rv = 1'b1; rls = 2'(sym % 3); len = $urandom_range(1, 20);
         end
         for (int i = 0; i < len; i++) begin
            step(rv, rls);
            check_model("rand");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
